exc_ctrl: RTL

//  Exception/interrupt sequencer between the MEM-stage commit point and cp0. Picks one event per

---
 rtl/exc_ctrl_pkg.sv | 45 ++++
 rtl/exc_ctrl_ost_counter.sv | 49 ++++
 rtl/exc_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared types, excodes and helpers for the exception/interrupt sequencer.
package exc_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        EXS_IDLE   = 2'd0,
        EXS_DRAIN  = 2'd1,
        EXS_COMMIT = 2'd2,
        EXS_REDIR  = 2'd3
    } exs_state_e;

    // MIPS excodes used by this block and its neighbours
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Status.BEV bit position
    localparam int STATUS_BEV = 22;

    // Event fields captured at the commit point
    typedef struct packed {
        logic [4:0]  excode;
        logic        bd;
        logic [31:0] epc;
        logic [31:0] badvaddr;
        logic        eret;
    } exc_info_t;

    // Restart pc: a delay-slot instr restarts at its branch (wraps mod 2^32)
    function automatic logic [31:0] calc_epc(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

    // Exception vector selected by Status.BEV
    function automatic logic [31:0] sel_vector(input logic bev,
                                               input logic [31:0] v_bev,
                                               input logic [31:0] v_norm);
        return bev ? v_bev : v_norm;
    endfunction

endpackage

// File: rtl/exc_ctrl_ost_counter.sv
// Outstanding data-transaction counter: up on request handshake, down on
// response, saturating at both ends, with a full flag for request blocking.
module exc_ctrl_ost_counter #(
    parameter int OST_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [OST_W-1:0] o_cnt,
    output logic [OST_W-1:0] o_cnt_next,
    output logic             o_full
);

    localparam logic [OST_W-1:0] CNT_MAX  = {OST_W{1'b1}};
    localparam logic [OST_W-1:0] CNT_ZERO = {OST_W{1'b0}};
    localparam logic [OST_W-1:0] CNT_ONE  = {{(OST_W-1){1'b0}}, 1'b1};

    logic [OST_W-1:0] r_cnt;
    logic [OST_W-1:0] w_cnt_next;

    // Next count: simultaneous inc/dec cancel; inc at full and dec at zero are dropped
    always_comb begin
        w_cnt_next = r_cnt;
        if (i_inc && i_dec) begin
            w_cnt_next = r_cnt;
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            w_cnt_next = r_cnt + CNT_ONE;
        end else if (i_dec && (r_cnt != CNT_ZERO)) begin
            w_cnt_next = r_cnt - CNT_ONE;
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= CNT_ZERO;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign o_cnt      = r_cnt;
    assign o_cnt_next = w_cnt_next;
    assign o_full     = (r_cnt == CNT_MAX);

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: accepts one event at the commit point,
// drains outstanding data transactions, pulses cp0, flushes and redirects fetch.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter int          OST_W    = 3,
    parameter logic [31:0] VEC_BEV  = 32'hBFC0_0380,
    parameter logic [31:0] VEC_NORM = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m_valid,
    input  logic        m_exc,
    input  logic [4:0]  m_excode,
    input  logic        m_eret,
    input  logic        m_bd,
    input  logic [31:0] m_pc,
    input  logic [31:0] m_badvaddr,
    input  logic        int_pending,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_epc,
    input  logic        cp0_wr_pend,
    input  logic        d_req_hs,
    input  logic        d_resp,
    output logic        d_req_block,
    output logic        commit_stall,
    output logic        exc_valid,
    output logic [4:0]  exc_excode,
    output logic        exc_bd,
    output logic [31:0] exc_epc,
    output logic [31:0] exc_badvaddr,
    output logic        exc_eret,
    output logic        flush,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    input  logic        redir_ready
);

    exs_state_e       r_state;
    exs_state_e       w_next_state;
    exc_info_t        r_info;
    exc_info_t        w_info;
    logic [31:0]      r_redir_pc;
    logic [OST_W-1:0] w_ost;
    logic [OST_W-1:0] w_ost_next;
    logic             w_ost_full;
    logic             w_candidate;
    logic             w_accept;

    exc_ctrl_ost_counter #(.OST_W(OST_W)) u_ost (
        .clk        (clk),
        .rst_n      (resetn),
        .i_inc      (d_req_hs),
        .i_dec      (d_resp),
        .o_cnt      (w_ost),
        .o_cnt_next (w_ost_next),
        .o_full     (w_ost_full)
    );

    assign d_req_block = w_ost_full;

    // Anything at the commit point that needs holding; eret waits for in-flight mtc0
    assign w_candidate = m_valid && (int_pending || m_exc || m_eret);
    assign w_accept    = m_valid && (int_pending || m_exc || (m_eret && !cp0_wr_pend));

    // Event fields to capture, resolved by priority interrupt > exception > eret
    always_comb begin
        w_info          = '0;
        w_info.bd       = m_bd;
        w_info.epc      = calc_epc(m_pc, m_bd);
        w_info.badvaddr = m_badvaddr;
        if (int_pending) begin
            w_info.excode = EXC_INT;
            w_info.eret   = 1'b0;
        end else if (m_exc) begin
            w_info.excode = m_excode;
            w_info.eret   = 1'b0;
        end else begin
            w_info.excode = EXC_INT;
            w_info.eret   = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= EXS_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; skip DRAIN when the counter is empty after this cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            EXS_IDLE: begin
                if (w_accept) begin
                    w_next_state = (w_ost_next != {OST_W{1'b0}}) ? EXS_DRAIN : EXS_COMMIT;
                end else begin
                    w_next_state = EXS_IDLE;
                end
            end
            EXS_DRAIN: begin
                if (w_ost == {OST_W{1'b0}}) begin
                    w_next_state = EXS_COMMIT;
                end else begin
                    w_next_state = EXS_DRAIN;
                end
            end
            EXS_COMMIT: w_next_state = EXS_REDIR;
            EXS_REDIR: begin
                if (redir_ready) begin
                    w_next_state = EXS_IDLE;
                end else begin
                    w_next_state = EXS_REDIR;
                end
            end
            default: w_next_state = EXS_IDLE;
        endcase
    end

    // Capture event fields when an event is accepted
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_info <= '0;
        end else if ((r_state == EXS_IDLE) && w_accept) begin
            r_info <= w_info;
        end else begin
            r_info <= r_info;
        end
    end

    // Capture redirect target in COMMIT (EPC sampled then, after any mtc0 landed)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_redir_pc <= 32'h0000_0000;
        end else if (r_state == EXS_COMMIT) begin
            r_redir_pc <= r_info.eret ? cp0_epc
                                      : sel_vector(cp0_status[STATUS_BEV], VEC_BEV, VEC_NORM);
        end else begin
            r_redir_pc <= r_redir_pc;
        end
    end

    // Outputs per state; data fields are zero outside the state that qualifies them
    always_comb begin
        commit_stall = 1'b0;
        exc_valid    = 1'b0;
        exc_excode   = 5'd0;
        exc_bd       = 1'b0;
        exc_epc      = 32'h0000_0000;
        exc_badvaddr = 32'h0000_0000;
        exc_eret     = 1'b0;
        flush        = 1'b0;
        redir_valid  = 1'b0;
        redir_pc     = 32'h0000_0000;
        case (r_state)
            EXS_IDLE: begin
                commit_stall = w_candidate;
            end
            EXS_DRAIN: begin
                commit_stall = 1'b1;
            end
            EXS_COMMIT: begin
                commit_stall = 1'b1;
                exc_valid    = 1'b1;
                exc_excode   = r_info.excode;
                exc_bd       = r_info.bd;
                exc_epc      = r_info.epc;
                exc_badvaddr = r_info.badvaddr;
                exc_eret     = r_info.eret;
                flush        = 1'b1;
            end
            EXS_REDIR: begin
                commit_stall = 1'b1;
                flush        = 1'b1;
                redir_valid  = 1'b1;
                redir_pc     = r_redir_pc;
            end
            default: begin
                commit_stall = 1'b0;
            end
        endcase
    end

endmodule
